// File: rtl/seq_bin_to_bcd.sv
// Sequential double-dabble binary-to-BCD converter, one shift per clock.
// The BCD result is registered and held between conversions to keep the displays steady.
module seq_bin_to_bcd #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]   scratch_q, scratch_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ovf_q, ovf_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            overflow_q, overflow_d;
  logic            done_q, done_d;
  logic [BW-1:0]   adj;
  logic            ovf_bit;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    scratch_d  = scratch_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    adj        = '0;
    ovf_bit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d   = bin;
          scratch_d = '0;
          cnt_d     = '0;
          ovf_d     = 1'b0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        for (int unsigned k = 0; k < DIGITS; k++) begin
          adj[4*k +: 4] = (scratch_q[4*k +: 4] >= 4'd5) ? scratch_q[4*k +: 4] + 4'd3
                                                        : scratch_q[4*k +: 4];
        end
        // The bit pushed out of the top digit is a carry into a digit we do not keep.
        {ovf_bit, scratch_d, shift_d} = {adj, shift_q, 1'b0};
        ovf_d = ovf_q | ovf_bit;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        bcd_d      = scratch_q;
        overflow_d = ovf_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      scratch_q  <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      scratch_q  <= scratch_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign bcd      = bcd_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Bench for seq_bin_to_bcd: cycle-level behavioural model for the 8-bit instance,
// directed literal checks on both the 8-bit and a 10-bit instance.
module tb_seq_bin_to_bcd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start;
  logic [7:0] bin;
  logic       busy, done, overflow;
  logic [11:0] bcd;

  logic       reset2, start2;
  logic [9:0] bin2;
  logic       busy2, done2, overflow2;
  logic [11:0] bcd2;

  int ntests = 0;
  int nfail  = 0;

  seq_bin_to_bcd #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset(reset), .start(start), .bin(bin),
    .busy(busy), .done(done), .bcd(bcd), .overflow(overflow)
  );

  seq_bin_to_bcd #(.WIDTH(10), .DIGITS(3)) dut10 (
    .clk(clk), .reset(reset2), .start(start2), .bin(bin2),
    .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntests++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int value);
    int v;
    logic [11:0] r;
    v = value;
    r = '0;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Behavioural model of the 8-bit instance: a conversion takes WIDTH+1 edges.
  int         rem = 0;
  int         lat = 0;
  logic       m_busy = 1'b0, m_done = 1'b0, m_ovf = 1'b0;
  logic [11:0] m_bcd = '0;
  bit         m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      rem = 0; m_done = 1'b0; m_bcd = '0; m_ovf = 1'b0; m_valid = 1'b1;
    end else begin
      m_done = 1'b0;
      if (rem == 0) begin
        if (start) begin
          rem = 9;
          lat = int'(bin);
        end
      end else begin
        rem--;
        if (rem == 0) begin
          m_done = 1'b1;
          m_bcd  = to_bcd(lat % 1000);
          m_ovf  = (lat >= 1000);
        end
      end
    end
    m_busy = (rem != 0);
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model busy",     busy,     m_busy);
      chk("model done",     done,     m_done);
      chk("model bcd",      bcd,      m_bcd);
      chk("model overflow", overflow, m_ovf);
    end
  end

  task automatic wait_done1(output int n, output int nb);
    n  = 0;
    nb = busy ? 1 : 0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      if (done) break;
      if (busy) nb++;
    end
  endtask

  task automatic conv1(input logic [7:0] v, input logic [11:0] e, input string nm);
    int n, nb;
    @(posedge clk); #1;
    start = 1'b1; bin = v;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done1(n, nb);
    chk({nm, " latency"}, n, 9);
    chk({nm, " busy cycles"}, nb, 9);
    chk({nm, " bcd"}, bcd, e);
    chk({nm, " overflow"}, overflow, 0);
  endtask

  task automatic conv2(input logic [9:0] v, input logic [11:0] e, input logic eo, input string nm);
    int n;
    @(posedge clk); #1;
    start2 = 1'b1; bin2 = v;
    @(posedge clk); #1;
    start2 = 1'b0;
    n = 0;
    while (n < 30) begin
      @(posedge clk); #1;
      n++;
      if (done2) break;
    end
    chk({nm, " latency"}, n, 11);
    chk({nm, " bcd"}, bcd2, e);
    chk({nm, " overflow"}, overflow2, eo);
  endtask

  initial begin
    int n, nb;
    bit seen;
    reset = 1'b1; start = 1'b0; bin = '0;
    reset2 = 1'b1; start2 = 1'b0; bin2 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset bcd", bcd, 0);
    chk("reset overflow", overflow, 0);
    chk("reset busy w10", busy2, 0);
    reset = 1'b0; reset2 = 1'b0;

    conv1(8'd255, 12'h255, "bin255");
    conv1(8'd0,   12'h000, "bin0");
    conv1(8'd7,   12'h007, "bin7");
    conv1(8'd100, 12'h100, "bin100");

    // start held high, bin changed while busy
    @(posedge clk); #1;
    start = 1'b1; bin = 8'd42;
    @(posedge clk); #1;
    bin = 8'd99;
    wait_done1(n, nb);
    chk("hold42 latency", n, 9);
    chk("hold42 bcd", bcd, 12'h042);
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold42 held", bcd, 12'h042);
    wait_done1(n, nb);
    chk("next99 latency", n, 9);
    chk("next99 bcd", bcd, 12'h099);

    // back-to-back start in the done cycle
    start = 1'b1; bin = 8'd128;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("b2b held", bcd, 12'h099);
    wait_done1(n, nb);
    chk("b2b latency rest", n, 5);
    chk("b2b bcd", bcd, 12'h128);

    // reset during the 4th SHIFT cycle
    @(posedge clk); #1;
    start = 1'b1; bin = 8'd77;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort bcd", bcd, 0);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort no done", seen, 0);
    conv1(8'd200, 12'h200, "bin200");

    conv2(10'd999,  12'h999, 1'b0, "w10 999");
    conv2(10'd1000, 12'h000, 1'b1, "w10 1000");
    conv2(10'd1023, 12'h023, 1'b1, "w10 1023");
    conv2(10'd512,  12'h512, 1'b0, "w10 512");

    repeat (400) begin
      @(posedge clk); #1;
      start = ($urandom % 3 == 0);
      bin   = 8'($urandom);
      reset = ($urandom % 80 == 0);
    end
    @(posedge clk); #1;
    start = 1'b0; reset = 1'b0;
    repeat (12) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
